ysyx_22040759_axi_arbiter: RTL and testbench

//  Two-requester arbiter in front of the single AXI read/write master port.

---
 rtl/ysyx_22040759_axi_arbiter.sv | 152 +++++++++++++++
 tb/tb_ysyx_22040759_axi_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040759_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_axi_arbiter
//
// Purpose:
//   Shares the single AXI read/write master port between instruction fetch
//   (IF, read-only) and the load/store unit (MEM, read or write).
//   MEM has fixed priority over IF, but after MEM_STREAK_MAX consecutive MEM
//   grants taken while IF was waiting, the next grant goes to IF.
//   The winner's request fields are latched and held on the rw_* side until
//   the master reports completion. The response then comes back to the
//   winner as a one-cycle ready pulse.
//
// Ports:
//   clk, rst              clock (rising edge), async reset (active-low)
//   if_valid/if_addr      fetch request in
//   if_ready/if_data_read fetch completion pulse and read data
//   mem_valid/mem_wen/mem_addr/mem_size/mem_wdata/mem_wstrb
//                         load/store request in
//   mem_ready/mem_rdata   load/store completion pulse and load data
//   rw_valid/rw_req/rw_addr/rw_size/rw_w_data/rw_w_mask
//                         latched request towards the AXI master
//   rw_ready/rw_r_data/rw_resp
//                         completion, read data and response from the master
//   bus_err/bus_err_addr  sticky error flag and address of the first error
// ----------------------------------------------------------------------------
module ysyx_22040759_axi_arbiter #(
    parameter int MEM_STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [63:0] if_data_read,
    input  logic        mem_valid,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_size,
    input  logic [63:0] mem_wdata,
    input  logic [7:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [63:0] mem_rdata,
    output logic        rw_valid,
    output logic        rw_req,
    output logic [31:0] rw_addr,
    output logic [1:0]  rw_size,
    output logic [63:0] rw_w_data,
    output logic [7:0]  rw_w_mask,
    input  logic        rw_ready,
    input  logic [63:0] rw_r_data,
    input  logic [1:0]  rw_resp,
    output logic        bus_err,
    output logic [31:0] bus_err_addr
);

    localparam int STREAK_W = $clog2(MEM_STREAK_MAX) + 1;
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MEM_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state;
    logic [STREAK_W-1:0] streak;
    logic                mem_wins;

    // MEM wins unless IF is waiting and MEM has already used up its streak.
    assign mem_wins = mem_valid && !(if_valid && (streak == STREAK_LIMIT));

    // Single FSM with all outputs registered. Requester inputs are only
    // looked at in IDLE, so anything they do during a grant is ignored.
    // Reset drops rw_valid at once; an in-flight response is simply lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            streak       <= '0;
            if_ready     <= 1'b0;
            if_data_read <= '0;
            mem_ready    <= 1'b0;
            mem_rdata    <= '0;
            rw_valid     <= 1'b0;
            rw_req       <= 1'b0;
            rw_addr      <= '0;
            rw_size      <= '0;
            rw_w_data    <= '0;
            rw_w_mask    <= '0;
            bus_err      <= 1'b0;
            bus_err_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_wins) begin
                        rw_valid  <= 1'b1;
                        rw_req    <= mem_wen;
                        rw_addr   <= mem_addr;
                        rw_size   <= mem_size;
                        rw_w_data <= mem_wdata;
                        rw_w_mask <= mem_wen ? mem_wstrb : 8'h00;
                        // The streak only grows while IF is actually kept waiting.
                        if (if_valid) begin
                            if (streak != STREAK_LIMIT) begin
                                streak <= streak + 1'b1;
                            end
                        end else begin
                            streak <= '0;
                        end
                        state <= GNT_MEM;
                    end else if (if_valid) begin
                        rw_valid  <= 1'b1;
                        rw_req    <= 1'b0;
                        rw_addr   <= if_addr;
                        rw_size   <= 2'd3;
                        rw_w_data <= '0;
                        rw_w_mask <= 8'h00;
                        streak    <= '0;
                        state     <= GNT_IF;
                    end
                end
                GNT_IF, GNT_MEM: begin
                    if (rw_ready) begin
                        rw_valid <= 1'b0;
                        if (state == GNT_MEM) begin
                            mem_rdata <= rw_r_data;
                            mem_ready <= 1'b1;
                        end else begin
                            if_data_read <= rw_r_data;
                            if_ready     <= 1'b1;
                        end
                        // Only the first error is recorded; the transfer still completes.
                        if ((rw_resp != 2'b00) && !bus_err) begin
                            bus_err      <= 1'b1;
                            bus_err_addr <= rw_addr;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22040759_axi_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040759_axi_arbiter
//
// Directed bench for the IF/MEM arbiter. The bench plays the AXI master:
// it answers each grant after a chosen number of wait cycles. Every request
// pushes its expected completion (winner and data) into a scoreboard queue,
// which is popped when the DUT produces the ready pulse.
// ----------------------------------------------------------------------------
module tb_ysyx_22040759_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [63:0] if_data_read;
    logic        mem_valid = 1'b0;
    logic        mem_wen = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [1:0]  mem_size = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        rw_valid;
    logic        rw_req;
    logic [31:0] rw_addr;
    logic [1:0]  rw_size;
    logic [63:0] rw_w_data;
    logic [7:0]  rw_w_mask;
    logic        rw_ready = 1'b0;
    logic [63:0] rw_r_data = '0;
    logic [1:0]  rw_resp = '0;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    typedef struct {
        logic        isMem;
        logic        checkData;
        logic [63:0] data;
    } exp_t;

    exp_t sbQueue[$];
    int   errors = 0;
    int   checks = 0;
    int   cycleCount = 0;
    int   readyCycle = 0;
    int   startCycle = 0;

    ysyx_22040759_axi_arbiter #(.MEM_STREAK_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_addr      (if_addr),
        .if_ready     (if_ready),
        .if_data_read (if_data_read),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_size     (mem_size),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .rw_valid     (rw_valid),
        .rw_req       (rw_req),
        .rw_addr      (rw_addr),
        .rw_size      (rw_size),
        .rw_w_data    (rw_w_data),
        .rw_w_mask    (rw_w_mask),
        .rw_ready     (rw_ready),
        .rw_r_data    (rw_r_data),
        .rw_resp      (rw_resp),
        .bus_err      (bus_err),
        .bus_err_addr (bus_err_addr)
    );

    always #5 clk = ~clk;

    // Last-resort guard so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input logic isMem, input logic checkData, input logic [63:0] data);
        exp_t e;
        e.isMem     = isMem;
        e.checkData = checkData;
        e.data      = data;
        sbQueue.push_back(e);
    endtask

    // Acts as the AXI master for one transfer: waits (bounded) for rw_valid,
    // stalls waitCycles, returns one completion, then checks the ready pulse
    // against the scoreboard and that it lasts exactly one cycle.
    task automatic applyStimulus(input int waitCycles, input logic [63:0] rdata,
                                 input logic [1:0] resp);
        int   n = 0;
        exp_t e;
        while (!rw_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("grant_seen", {63'd0, rw_valid}, 64'd1);
        if (rw_valid) begin
            repeat (waitCycles) tick();
            rw_ready  = 1'b1;
            rw_r_data = rdata;
            rw_resp   = resp;
            tick();
            rw_ready  = 1'b0;
            rw_resp   = 2'b00;
            rw_r_data = '0;
            readyCycle = cycleCount;
            checkOutput("rw_valid_in_done", {63'd0, rw_valid}, 64'd0);
            if (sbQueue.size() == 0) begin
                checkOutput("sb_underflow", 64'(sbQueue.size()), 64'd1);
            end else begin
                e = sbQueue.pop_front();
                checkOutput("ready_winner", {62'd0, mem_ready, if_ready},
                            e.isMem ? 64'd2 : 64'd1);
                if (e.checkData) begin
                    checkOutput("ready_data", e.isMem ? mem_rdata : if_data_read, e.data);
                end
            end
            tick();
            checkOutput("ready_cleared", {62'd0, mem_ready, if_ready}, 64'd0);
        end
    endtask

    logic order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        // Reset held with both requesters pending: everything must read 0.
        $display("[TB] reset with both requesters pending");
        mem_valid = 1'b1;
        mem_wen   = 1'b0;
        mem_addr  = 32'h8000_2000;
        mem_size  = 2'd2;
        if_valid  = 1'b1;
        if_addr   = 32'h8000_0100;
        repeat (3) tick();
        checkOutput("rst_rw_valid", {63'd0, rw_valid}, 64'd0);
        checkOutput("rst_readies", {62'd0, mem_ready, if_ready}, 64'd0);
        checkOutput("rst_rw_addr", {32'd0, rw_addr}, 64'd0);
        checkOutput("rst_bus_err", {63'd0, bus_err}, 64'd0);
        checkOutput("rst_bus_err_addr", {32'd0, bus_err_addr}, 64'd0);
        checkOutput("rst_mem_rdata", mem_rdata, 64'd0);
        rst = 1'b1;
        tick();
        checkOutput("first_grant_addr", {32'd0, rw_addr}, 64'h8000_2000);
        checkOutput("first_grant_size", {62'd0, rw_size}, 64'd2);
        mem_valid = 1'b0;
        if_valid  = 1'b0;
        pushExpect(1'b1, 1'b1, 64'h0000_00A5);
        applyStimulus(0, 64'h0000_00A5, 2'b00);

        // Fetch with one bus wait cycle: 4-cycle request-to-ready latency.
        $display("[TB] fetch with one wait cycle");
        if_valid   = 1'b1;
        if_addr    = 32'h8000_0000;
        startCycle = cycleCount;
        tick();
        checkOutput("if_rw_size", {62'd0, rw_size}, 64'd3);
        checkOutput("if_rw_req", {63'd0, rw_req}, 64'd0);
        checkOutput("if_rw_mask", {56'd0, rw_w_mask}, 64'd0);
        checkOutput("if_rw_addr", {32'd0, rw_addr}, 64'h8000_0000);
        if_valid = 1'b0;
        pushExpect(1'b0, 1'b1, 64'h0000_0013);
        applyStimulus(1, 64'h0000_0013, 2'b00);
        checkOutput("if_latency", 64'(readyCycle - startCycle + 1), 64'd4);
        checkOutput("if_data_held", if_data_read, 64'h0000_0013);

        // Store whose address changes mid-grant: latched fields must hold.
        $display("[TB] store with changing requester inputs");
        mem_valid = 1'b1;
        mem_wen   = 1'b1;
        mem_addr  = 32'h8000_1000;
        mem_size  = 2'd2;
        mem_wdata = 64'h0000_0000_DEAD_BEEF;
        mem_wstrb = 8'h0F;
        tick();
        checkOutput("st_rw_req", {63'd0, rw_req}, 64'd1);
        checkOutput("st_rw_mask", {56'd0, rw_w_mask}, 64'h0F);
        checkOutput("st_rw_wdata", rw_w_data, 64'h0000_0000_DEAD_BEEF);
        mem_addr  = 32'h1234_5678;
        mem_wdata = 64'h1111_2222_3333_4444;
        mem_wstrb = 8'hF0;
        tick();
        checkOutput("st_rw_addr_held", {32'd0, rw_addr}, 64'h8000_1000);
        checkOutput("st_rw_mask_held", {56'd0, rw_w_mask}, 64'h0F);
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
        pushExpect(1'b1, 1'b0, 64'd0);
        applyStimulus(0, 64'd0, 2'b00);

        // Both held high: MEM x4, then IF breaks the streak, then MEM again.
        $display("[TB] streak limit with both requesters held");
        mem_valid = 1'b1;
        mem_addr  = 32'h8000_3000;
        if_valid  = 1'b1;
        if_addr   = 32'h8000_0200;
        for (int i = 0; i < 6; i++) begin
            pushExpect(order[i], 1'b1, 64'h100 + 64'(i));
            applyStimulus(0, 64'h100 + 64'(i), 2'b00);
        end
        mem_valid = 1'b0;
        if_valid  = 1'b0;

        // Error responses: first one is recorded, the second is ignored.
        $display("[TB] sticky bus error");
        mem_valid = 1'b1;
        mem_addr  = 32'h1000_0000;
        pushExpect(1'b1, 1'b1, 64'hE1);
        tick();
        mem_valid = 1'b0;
        applyStimulus(0, 64'hE1, 2'd2);
        checkOutput("err_flag_1", {63'd0, bus_err}, 64'd1);
        checkOutput("err_addr_1", {32'd0, bus_err_addr}, 64'h1000_0000);
        mem_valid = 1'b1;
        mem_addr  = 32'h2000_0000;
        pushExpect(1'b1, 1'b1, 64'hE2);
        tick();
        mem_valid = 1'b0;
        applyStimulus(0, 64'hE2, 2'd3);
        checkOutput("err_flag_2", {63'd0, bus_err}, 64'd1);
        checkOutput("err_addr_2", {32'd0, bus_err_addr}, 64'h1000_0000);

        // Reset in the middle of a fetch grant.
        $display("[TB] reset during fetch grant");
        if_valid = 1'b1;
        if_addr  = 32'h8000_0400;
        tick();
        checkOutput("pre_rst_rw_valid", {63'd0, rw_valid}, 64'd1);
        if_valid = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_rw_valid", {63'd0, rw_valid}, 64'd0);
        rw_ready  = 1'b1;
        rw_r_data = 64'hBAD;
        tick();
        rw_ready  = 1'b0;
        rw_r_data = '0;
        checkOutput("rst_no_if_ready", {63'd0, if_ready}, 64'd0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_rw_valid", {63'd0, rw_valid}, 64'd0);
        checkOutput("post_rst_readies", {62'd0, mem_ready, if_ready}, 64'd0);
        checkOutput("post_rst_bus_err", {63'd0, bus_err}, 64'd0);
        checkOutput("post_rst_if_data", if_data_read, 64'd0);
        tick();
        checkOutput("post_rst_idle", {63'd0, rw_valid}, 64'd0);

        checkOutput("sb_drained", 64'(sbQueue.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
